// File: rtl/ahb_debug_regfile.sv
// AHB-Lite slave exposing NUM_REGS 32-bit debug registers with byte-lane writes,
// optional data-phase wait states and a two-cycle ERROR response for misaligned accesses.
module ahb_debug_regfile #(
    parameter int          NUM_REGS    = 2,
    parameter logic [23:0] BASE_ADDR   = 24'hFFFFF8,
    parameter int          WAIT_STATES = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [31:0]            HWDATA,
    input  logic                   HREADY,
    output logic [31:0]            HRDATA,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [NUM_REGS*32-1:0] dbg_reg_o,
    output logic [NUM_REGS-1:0]    dbg_wr_pulse_o
);
    localparam int          IDX_W     = $clog2(NUM_REGS);
    localparam logic [24:0] WIN_BYTES = 25'(4 * NUM_REGS);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t                    state, next_state;
    logic [2:0]                wait_cnt;
    logic [NUM_REGS-1:0][31:0] regs;

    // Latched address-phase information for the data phase in flight.
    logic                      dp_valid;
    logic                      dp_write;
    logic [IDX_W-1:0]          dp_idx;
    logic [3:0]                dp_lanes;

    logic [23:0]               addr;
    logic [23:0]               offset;
    logic                      accept;
    logic                      in_window;
    logic                      illegal;
    logic                      phase_end;
    logic                      complete;
    logic                      commit;
    logic [3:0]                lanes;
    logic [31:0]               merged;

    assign addr      = HADDR[23:0];
    assign offset    = addr - BASE_ADDR;
    assign accept    = HSEL & HREADY & HTRANS[1];
    assign in_window = (addr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
    assign illegal   = (HSIZE > 3'd2) ||
                       (HSIZE == 3'd1 && HADDR[0]) ||
                       (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        lanes = 4'b1111;
        case (HSIZE)
            3'd0:    lanes = 4'b0001 << HADDR[1:0];
            3'd1:    lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        phase_end  = 1'b0;
        case (state)
            IDLE, ERR2: begin
                HRESP      = (state == ERR2);
                phase_end  = 1'b1;
                next_state = IDLE;
                if (accept && in_window) begin
                    if (illegal)              next_state = ERR1;
                    else if (WAIT_STATES > 0) next_state = WAIT;
                end
            end
            WAIT: begin
                HREADYOUT = 1'b0;
                if (wait_cnt == 3'd0) next_state = IDLE;
            end
            ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                next_state = ERR2;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_lanes <= '0;
            wait_cnt <= '0;
        end else begin
            if (phase_end) begin
                dp_valid <= accept && in_window && !illegal;
                dp_write <= HWRITE;
                dp_idx   <= offset[IDX_W+1:2];
                dp_lanes <= lanes;
                if (next_state == WAIT) wait_cnt <= 3'(WAIT_STATES - 1);
            end
            if (state == WAIT && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // The data phase completes in IDLE; WAIT always hands over to IDLE for the final cycle.
    assign complete = dp_valid && (state == IDLE);
    assign commit   = complete && dp_write;

    always_comb begin
        merged = regs[dp_idx];
        for (int b = 0; b < 4; b++) begin
            if (dp_lanes[b]) merged[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: the register array is reset, unlike a RAM, because software expects zeros after reset.
        if (!HRESETn) begin
            regs           <= '0;
            dbg_wr_pulse_o <= '0;
        end else begin
            dbg_wr_pulse_o <= '0;
            if (commit) begin
                regs[dp_idx]           <= merged;
                dbg_wr_pulse_o[dp_idx] <= 1'b1;
            end
        end
    end

    assign HRDATA    = (complete && !dp_write) ? regs[dp_idx] : 32'd0;
    assign dbg_reg_o = regs;

    // Address bits outside the decoded window range are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{HADDR[31:24], offset[23:IDX_W+2], offset[1:0]};
endmodule

// File: tb/tb_ahb_debug_regfile.sv
// Scoreboard bench for ahb_debug_regfile: one zero-wait and one three-wait instance,
// driven by directed and random AHB transfers checked against a byte-array reference model.
module tb_ahb_debug_regfile;
    localparam int          NR   = 2;
    localparam logic [23:0] BASE = 24'hFFFFF8;
    localparam int          WS1  = 3;

    logic hclk = 1'b0;
    logic hresetn;
    logic stall = 1'b0;
    always #5 hclk = ~hclk;

    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [31:0] hwdata    [2];
    logic        hready    [2];
    logic [31:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [63:0] dbg_reg   [2];
    logic [1:0]  dbg_pulse [2];

    // stall models another slave holding the shared HREADY low.
    assign hready[0] = hreadyout[0] & ~stall;
    assign hready[1] = hreadyout[1] & ~stall;

    ahb_debug_regfile #(.NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
        .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]),
        .dbg_reg_o(dbg_reg[0]), .dbg_wr_pulse_o(dbg_pulse[0]));

    ahb_debug_regfile #(.NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(WS1)) u_dut1 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
        .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]),
        .dbg_reg_o(dbg_reg[1]), .dbg_wr_pulse_o(dbg_pulse[1]));

    typedef struct {
        logic        err;
        logic        wr;
        logic [31:0] rdata;
        int          waits;
        int          idx;
        logic [63:0] regs;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [2][NR];
    int          cur = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pend_wdata = 32'd0;
    logic        mon_active = 1'b0;
    logic [1:0]  exp_pulse = 2'b00;
    logic        chk_regs = 1'b0;
    logic [63:0] regs_exp = 64'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (dut%0d): got %h expected %h at %0t", name, cur, act, req, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : WS1;
    endfunction

    // Reference model: decode, legality and byte merge from plain address arithmetic.
    task automatic model_access(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                                input logic [31:0] wdata);
        int unsigned a      = addr[23:0];
        int unsigned base_i = 32'(BASE);
        bit          inw    = (a >= base_i) && (a < base_i + 4 * NR);
        int          idx    = inw ? int'((a - base_i) / 4) : 0;
        bit          ill    = inw && (size > 2 || (size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0));
        exp_t        e;
        e.err   = ill;
        e.wr    = wr && inw && !ill;
        e.rdata = (!wr && inw && !ill) ? model[cur][idx] : 32'd0;
        e.waits = ill ? 1 : (inw ? ws_of(cur) : 0);
        e.idx   = idx;
        if (e.wr) begin
            for (int b = int'(a % 4); b < int'(a % 4) + (1 << size); b++)
                model[cur][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        e.regs = {model[cur][1], model[cur][0]};
        q.push_back(e);
    endtask

    // Present one address phase on the current DUT; returns 1 time unit after it is taken.
    task automatic issue(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                         input logic wr, input logic [2:0] size, input logic [31:0] wdata);
        int n = 0;
        hsel[cur]   = sel;
        haddr[cur]  = addr;
        htrans[cur] = trans;
        hwrite[cur] = wr;
        hsize[cur]  = size;
        hwdata[cur] = pend_wdata;
        @(negedge hclk);
        while (!hready[cur] && n < 64) begin
            @(negedge hclk);
            n++;
        end
        check("hready_timeout", 64'(n >= 64), 64'(0));
        @(posedge hclk);
        if (sel && trans[1]) model_access(addr, wr, size, wdata);
        pend_wdata = wdata;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || mon_active) && n < 60) begin
            issue(1'b0, 32'd0, 2'b00, 1'b0, 3'd0, 32'd0);
            n++;
        end
        check("drain_pending", 64'(q.size()), 64'(0));
        q.delete();
        repeat (2) issue(1'b0, 32'd0, 2'b00, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < NR; r++) model[d][r] = 32'd0;
    endtask

    task automatic random_traffic(input int count);
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  trans;
        int          r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      addr = {8'($urandom), BASE + 24'($urandom_range(0, 7))};
            else if (r < 8) addr = {8'($urandom), 24'hFFFFF0 + 24'($urandom_range(0, 7))};
            else            addr = $urandom;
            size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            trans = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            issue($urandom_range(0, 9) != 0, addr, trans, 1'($urandom_range(0, 1)), size, $urandom);
        end
        drain();
    endtask

    // Monitor: pops one expectation per completed data phase of the current DUT.
    initial begin : monitor
        exp_t e;
        int   waits;
        logic low_resp;
        waits    = 0;
        low_resp = 1'b0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                mon_active = 1'b0;
                q.delete();
                exp_pulse  = 2'b00;
                chk_regs   = 1'b0;
            end else begin
                check("wr_pulse", 64'(dbg_pulse[cur]), 64'(exp_pulse));
                exp_pulse = 2'b00;
                if (chk_regs) check("dbg_reg", dbg_reg[cur], regs_exp);
                chk_regs = 1'b0;
                if (mon_active) begin
                    if (!hreadyout[cur]) begin
                        waits++;
                        low_resp = hresp[cur];
                        check("wait_bound", 64'(waits > 16), 64'(0));
                        if (waits > 16) mon_active = 1'b0;
                    end else begin
                        mon_active = 1'b0;
                        check("sb_expected", 64'(q.size() != 0), 64'(1));
                        if (q.size() != 0) begin
                            e = q.pop_front();
                            check("wait_cycles", 64'(waits), 64'(e.waits));
                            check("hresp", 64'(hresp[cur]), 64'(e.err));
                            check("hrdata", 64'(hrdata[cur]), 64'(e.rdata));
                            if (e.waits > 0) check("low_resp", 64'(low_resp), 64'(e.err));
                            exp_pulse = e.wr ? 2'(2'b01 << e.idx) : 2'b00;
                            regs_exp  = e.regs;
                            chk_regs  = 1'b1;
                        end
                    end
                end else begin
                    check("idle_ready", 64'(hreadyout[cur]), 64'(1));
                    check("idle_rdata", 64'(hrdata[cur]), 64'(0));
                end
                if (hready[cur] && hsel[cur] && htrans[cur][1]) begin
                    mon_active = 1'b1;
                    waits      = 0;
                    low_resp   = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = 32'd0; htrans[d] = 2'b00;
            hwrite[d] = 1'b0; hsize[d] = 3'd0; hwdata[d] = 32'd0;
        end
        reset_model();
        hresetn = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            cur = d;
            check("rst_ready", 64'(hreadyout[d]), 64'(1));
            check("rst_resp", 64'(hresp[d]), 64'(0));
            check("rst_rdata", 64'(hrdata[d]), 64'(0));
            check("rst_regs", dbg_reg[d], 64'd0);
            check("rst_pulse", 64'(dbg_pulse[d]), 64'(0));
        end
        cur = 0;
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // Word write to register 1 and read back.
        issue(1'b1, 32'h00FFFFFC, 2'b10, 1'b1, 3'd2, 32'hDEADBEEF);
        issue(1'b1, 32'h00FFFFFC, 2'b10, 1'b0, 3'd2, 32'd0);
        drain();
        check("deadbeef", 64'(dbg_reg[0][63:32]), 64'(32'hDEADBEEF));

        // Byte then halfword writes into register 0.
        issue(1'b1, 32'h00FFFFF8, 2'b10, 1'b1, 3'd2, 32'h00000000);
        issue(1'b1, 32'h00FFFFF9, 2'b10, 1'b1, 3'd0, 32'hA5A5A5A5);
        drain();
        check("byte_lane", 64'(dbg_reg[0][31:0]), 64'(32'h0000A500));
        issue(1'b1, 32'h00FFFFFA, 2'b11, 1'b1, 3'd1, 32'h12341234);
        drain();
        check("half_lane", 64'(dbg_reg[0][31:0]), 64'(32'h1234A500));

        // Misaligned word write errors and leaves register 0 alone.
        issue(1'b1, 32'h00FFFFF9, 2'b10, 1'b1, 3'd2, 32'hFFFFFFFF);
        drain();
        check("err_no_write", 64'(dbg_reg[0][31:0]), 64'(32'h1234A500));

        // Out-of-window write and read.
        issue(1'b1, 32'h00FFFFF0, 2'b10, 1'b1, 3'd2, 32'hCAFEF00D);
        issue(1'b1, 32'h00FFFFF0, 2'b10, 1'b0, 3'd2, 32'd0);
        drain();
        check("oow_no_write", dbg_reg[0], {32'hDEADBEEF, 32'h1234A500});

        // Address phase presented while HREADY is low must be ignored.
        stall      = 1'b1;
        pend_wdata = 32'hFFFFFFFF;
        hsel[0] = 1'b1; haddr[0] = 32'h00FFFFF8; htrans[0] = 2'b10;
        hwrite[0] = 1'b1; hsize[0] = 3'd2; hwdata[0] = 32'hFFFFFFFF;
        repeat (2) @(posedge hclk);
        #1;
        hsel[0] = 1'b0; htrans[0] = 2'b00;
        stall   = 1'b0;
        drain();
        check("stall_ignored", 64'(dbg_reg[0][31:0]), 64'(32'h1234A500));

        random_traffic(150);

        // Three-wait instance: read, then back-to-back write/read of register 1.
        cur        = 1;
        pend_wdata = 32'd0;
        issue(1'b1, 32'h00FFFFFC, 2'b10, 1'b0, 3'd2, 32'd0);
        issue(1'b1, 32'h00FFFFFC, 2'b10, 1'b1, 3'd2, 32'h5A5AC3C3);
        issue(1'b1, 32'h00FFFFFC, 2'b10, 1'b0, 3'd2, 32'd0);
        drain();
        check("ws_reg1", 64'(dbg_reg[1][63:32]), 64'(32'h5A5AC3C3));

        random_traffic(150);

        // Reset in the middle of a waited write.
        issue(1'b1, 32'h00FFFFF8, 2'b10, 1'b1, 3'd2, 32'h00000001);
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h00000001;
        @(negedge hclk);
        check("in_wait", 64'(hreadyout[1]), 64'(0));
        hresetn = 1'b0;
        #1;
        check("abort_ready", 64'(hreadyout[1]), 64'(1));
        check("abort_resp", 64'(hresp[1]), 64'(0));
        check("abort_rdata", 64'(hrdata[1]), 64'(0));
        check("abort_regs", dbg_reg[1], 64'd0);
        check("abort_pulse", 64'(dbg_pulse[1]), 64'(0));
        reset_model();
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        pend_wdata = 32'd0;
        issue(1'b1, 32'h00FFFFF8, 2'b10, 1'b0, 3'd2, 32'd0);
        drain();
        check("post_reset_reg0", 64'(dbg_reg[1][31:0]), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
